// File: rtl/agc_mon_pkg.sv
// Shared types and constants for the AGC monitor-interface controller.
package agc_mon_pkg;

    typedef enum logic [1:0] {
        MON_START = 2'd0,
        MON_LOAD  = 2'd1,
        MON_READ  = 2'd2,
        MON_HALT  = 2'd3
    } mon_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StPulse,
        StSetup,
        StWaitT1,
        StWaitTs,
        StWaitT12,
        StRelease,
        StResp
    } mon_state_e;

    // Bit positions of MT01 and MT12 within the MT bus.
    localparam logic [3:0] TP_MT01 = 4'd0;
    localparam logic [3:0] TP_MT12 = 4'd11;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/agc_mon_edge.sv
// Registers the AGC timepulse and GOJAM monitor lines once and flags their rising edges.
module agc_mon_edge (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] mt_i,
    input  logic        gojam_i,
    output logic [11:0] mt_rise_o,
    output logic        gj_rise_o
);

    logic [11:0] mt_q;
    logic        gj_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mt_q <= '0;
            gj_q <= 1'b0;
        end else begin
            mt_q <= mt_i;
            gj_q <= gojam_i;
        end
    end

    assign mt_rise_o = mt_i & ~mt_q;
    assign gj_rise_o = gojam_i & ~gj_q;

endmodule

// File: rtl/agc_monitor_ctl.sv
// Test-set controller driving the AGC monitor START/HALT/LOAD/READ handshakes.
// Define MON_GOJAM_ABORT_EN to abort in-flight commands on a rising MGOJAM.
module agc_monitor_ctl
    import agc_mon_pkg::*;
#(
    parameter int unsigned PULSE_CYC   = 250,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned SAMPLE_TP   = 7
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic [11:0] MT,
    input  logic        MGOJAM,
    input  logic [15:0] MWL,
    output logic        MSTRT,
    output logic        MSTP,
    output logic        MLOAD,
    output logic        MREAD,
    output logic [15:0] MDT
);

    localparam int unsigned CntMax = max3(PULSE_CYC, SETUP_CYC, TIMEOUT_CYC);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntPulse = CntW'(PULSE_CYC - 1);
    localparam logic [CntW-1:0] CntSetup = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] CntWait  = CntW'(TIMEOUT_CYC - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [3:0]      TpSample = 4'(SAMPLE_TP - 1);

    mon_state_e      state_q, state_d;
    mon_op_e         op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [15:0]     data_q, data_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mstrt_q, mstrt_d;
    logic        mstp_q, mstp_d;
    logic        mload_q, mload_d;
    logic        mread_q, mread_d;
    logic [15:0] mdt_q, mdt_d;

    logic [11:0] mt_rise;
    logic        gj_rise;
    logic        abort;
    logic        accept;
    logic        cnt_done;

    agc_mon_edge u_edge (
        .clk_i     (SIM_CLK),
        .rst_ni    (SIM_RST_n),
        .mt_i      (MT),
        .gojam_i   (MGOJAM),
        .mt_rise_o (mt_rise),
        .gj_rise_o (gj_rise)
    );

`ifdef MON_GOJAM_ABORT_EN
    assign abort = gj_rise;
`else
    logic unused_gj_rise;
    assign unused_gj_rise = gj_rise;
    assign abort          = 1'b0;
`endif

    assign accept   = cmd_valid & cmd_ready_q;
    assign cnt_done = (cnt_q == '0);

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            state_q     <= StIdle;
            op_q        <= MON_START;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            data_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mstrt_q     <= 1'b0;
            mstp_q      <= 1'b0;
            mload_q     <= 1'b0;
            mread_q     <= 1'b0;
            mdt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            data_q      <= data_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            mstrt_q     <= mstrt_d;
            mstp_q      <= mstp_d;
            mload_q     <= mload_d;
            mread_q     <= mread_d;
            mdt_q       <= mdt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d   = mon_op_e'(cmd_op);
                    err_d  = 1'b0;
                    data_d = '0;
                    unique case (op_d)
                        MON_START: begin
                            state_d = StPulse;
                            cnt_d   = CntPulse;
                        end
                        MON_LOAD: begin
                            state_d = StSetup;
                            cnt_d   = CntSetup;
                        end
                        MON_READ: begin
                            state_d = StWaitT1;
                            cnt_d   = CntWait;
                        end
                        MON_HALT: state_d = StRelease;
                    endcase
                end
            end
            StPulse, StSetup: begin
                if (abort) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else if (cnt_done) begin
                    state_d = (state_q == StPulse) ? StResp : StWaitT1;
                    cnt_d   = CntWait;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitT1: begin
                if (abort) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else if (mt_rise[TP_MT01]) begin
                    cnt_d = CntWait;
                    // With SAMPLE_TP=1 the sample edge coincides with MT01.
                    if (op_q == MON_READ && TpSample == TP_MT01) begin
                        data_d  = MWL;
                        state_d = StWaitT12;
                    end else if (op_q == MON_READ) begin
                        state_d = StWaitTs;
                    end else begin
                        state_d = StWaitT12;
                    end
                end else if (cnt_done) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitTs: begin
                if (abort) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else if (mt_rise[TpSample]) begin
                    data_d  = MWL;
                    state_d = StWaitT12;
                    cnt_d   = CntWait;
                end else if (cnt_done) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitT12: begin
                if (abort) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else if (mt_rise[TP_MT12]) begin
                    state_d = StRelease;
                end else if (cnt_done) begin
                    state_d = StRelease;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StRelease: state_d = StResp;
            StResp:    state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change with the state itself.
    always_comb begin
        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        rsp_err_d   = (state_d == StResp) & err_d;
        mstrt_d     = (state_d == StPulse);
        mload_d     = (op_d == MON_LOAD) && (state_d inside {StWaitT1, StWaitT12});
        mread_d     = (op_d == MON_READ) && (state_d inside {StWaitT1, StWaitTs, StWaitT12});
        mstp_d      = mstp_q;
        mdt_d       = mdt_q;
        if (accept && op_d == MON_HALT) begin
            mstp_d = cmd_data[0];
        end
        if (state_d == StIdle || state_d == StResp) begin
            mdt_d = '0;
        end else if (accept && op_d == MON_LOAD) begin
            mdt_d = cmd_data;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = data_q;
    assign MSTRT     = mstrt_q;
    assign MSTP      = mstp_q;
    assign MLOAD     = mload_q;
    assign MREAD     = mread_q;
    assign MDT       = mdt_q;

endmodule
